// File: rtl/spi_master_ctrl.sv
// Host-side SPI master: serialises 10-bit command words MSB-first and captures read-data bytes.
// Optional rd-data sequencing check enabled by defining SPI_MASTER_SEQ_CHECK_EN.
module spi_master_ctrl #(
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [9:0] cmd_data,
    output logic       cmd_ready,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       MOSI,
    input  logic       MISO,
    output logic       SS_n,
    output logic       seq_err
);

    typedef enum logic [2:0] {
        StIdle,
        StSel,
        StShift,
        StRdWait,
        StCapture
    } state_e;

    localparam logic [3:0] RdLastCnt = 4'(RD_LATENCY - 1);

    state_e     state_q;
    logic [9:0] shift_q;
    logic [3:0] cnt_q;
    logic       is_rd_q;
    logic [6:0] cap_q;
    logic       mosi_q;
    logic       ss_n_q;
    logic       rd_valid_q;
    logic [7:0] rd_data_q;

    logic accept;
    logic start_frame;

    assign cmd_ready = (state_q == StIdle) && !rst;
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = (state_q != StIdle);
    assign MOSI      = mosi_q;
    assign SS_n      = ss_n_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;

`ifdef SPI_MASTER_SEQ_CHECK_EN
    logic addr_pending_q;
    logic seq_err_q;
    logic seq_reject;

    // A rd-data command without a preceding rd-addr is swallowed instead of framed.
    assign seq_reject  = (cmd_data[9:8] == 2'b11) && !addr_pending_q;
    assign start_frame = accept && !seq_reject;
    assign seq_err     = seq_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_pending_q <= 1'b0;
            seq_err_q      <= 1'b0;
        end else begin
            seq_err_q <= accept && seq_reject;
            if (accept) begin
                if (cmd_data[9:8] == 2'b10) begin
                    addr_pending_q <= 1'b1;
                end else if (cmd_data[9:8] == 2'b11) begin
                    addr_pending_q <= 1'b0;
                end
            end
        end
    end
`else
    assign start_frame = accept;
    assign seq_err     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            shift_q    <= '0;
            cnt_q      <= '0;
            is_rd_q    <= 1'b0;
            cap_q      <= '0;
            mosi_q     <= 1'b0;
            ss_n_q     <= 1'b1;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    ss_n_q <= 1'b1;
                    mosi_q <= 1'b0;
                    if (start_frame) begin
                        shift_q <= cmd_data;
                        is_rd_q <= (cmd_data[9:8] == 2'b11);
                        ss_n_q  <= 1'b0;
                        mosi_q  <= cmd_data[9];
                        state_q <= StSel;
                    end
                end
                StSel: begin
                    mosi_q  <= shift_q[9];
                    shift_q <= {shift_q[8:0], 1'b0};
                    cnt_q   <= '0;
                    state_q <= StShift;
                end
                StShift: begin
                    if (cnt_q == 4'd9) begin
                        cnt_q  <= '0;
                        mosi_q <= 1'b0;
                        if (is_rd_q) begin
                            state_q <= StRdWait;
                        end else begin
                            ss_n_q  <= 1'b1;
                            state_q <= StIdle;
                        end
                    end else begin
                        mosi_q  <= shift_q[9];
                        shift_q <= {shift_q[8:0], 1'b0};
                        cnt_q   <= cnt_q + 4'd1;
                    end
                end
                StRdWait: begin
                    if (cnt_q == RdLastCnt) begin
                        cnt_q   <= '0;
                        state_q <= StCapture;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                StCapture: begin
                    cap_q <= {cap_q[5:0], MISO};
                    if (cnt_q == 4'd7) begin
                        rd_data_q  <= {cap_q, MISO};
                        rd_valid_q <= 1'b1;
                        ss_n_q     <= 1'b1;
                        cnt_q      <= '0;
                        state_q    <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Scoreboard bench for spi_master_ctrl: expected frames, reads and seq errors queued at issue time,
// checked by an independent monitor against observed SS_n/MOSI/rd_valid/seq_err activity.
module tb_spi_master_ctrl;

    parameter int unsigned RD_LATENCY = 2;
    localparam int L = int'(RD_LATENCY);

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic [9:0] cmd_data;
    logic       cmd_ready;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       busy;
    logic       MOSI;
    logic       MISO;
    logic       SS_n;
    logic       seq_err;

    spi_master_ctrl #(.RD_LATENCY(RD_LATENCY)) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_data (cmd_data),
        .cmd_ready(cmd_ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .busy     (busy),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .SS_n     (SS_n),
        .seq_err  (seq_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         t;
        logic [9:0] cmd;
        int         len;
        bit         aborted;
    } frm_t;

    typedef struct {
        int         t;
        logic [7:0] b;
    } rd_t;

    frm_t frm_q[$];
    rd_t  rd_q[$];
    rd_t  miso_q[$];
    int   err_q[$];

    int tests = 0;
    int fails = 0;
    bit mon_en = 0;
    bit pending = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, got, exp, cyc + 1);
        end
    endtask

    // Issue one command; must be called at a negedge. Returns the accept edge index.
    task automatic send(input logic [9:0] c, input logic [7:0] b, input bit hold, output int t);
        int  k;
        bit  rejected;
        frm_t fe;
        rd_t  re;
        k = 0;
        cmd_data  = c;
        cmd_valid = 1'b1;
        while (cmd_ready !== 1'b1) begin
            @(negedge clk);
            k++;
            if (k > 200) begin
                tests++;
                fails++;
                $display("FAIL accept_timeout: cmd 0x%0h not accepted within 200 cycles", c);
                cmd_valid = 1'b0;
                t = -1;
                return;
            end
        end
        t = cyc + 1;
        rejected = 0;
`ifdef SPI_MASTER_SEQ_CHECK_EN
        if (c[9:8] == 2'b10) pending = 1;
        else if (c[9:8] == 2'b11) begin
            if (!pending) rejected = 1;
            pending = 0;
        end
`endif
        if (rejected) begin
            err_q.push_back(t + 1);
        end else begin
            fe.t = t;
            fe.cmd = c;
            fe.len = (c[9:8] == 2'b11) ? 19 + L : 11;
            fe.aborted = 0;
            frm_q.push_back(fe);
            if (c[9:8] == 2'b11) begin
                re.t = t + 20 + L;
                re.b = b;
                rd_q.push_back(re);
                re.t = t + 12 + L;
                miso_q.push_back(re);
            end
        end
        @(negedge clk);
        if (!hold) cmd_valid = 1'b0;
    endtask

    // Slave model: presents the expected byte MSB-first in the sampling window, noise elsewhere.
    always @(negedge clk) begin
        int now;
        int s;
        now  = cyc + 1;
        MISO = 1'($urandom);
        if (miso_q.size() > 0) begin
            s = miso_q[0].t;
            if (now >= s && now < s + 8) MISO = miso_q[0].b[7 - (now - s)];
            if (now >= s + 7) void'(miso_q.pop_front());
        end
    end

    bit          in_frame = 0;
    int          fstart;
    int          nbits;
    int          kbits;
    bit          mosi_nz;
    logic [10:0] got;
    logic [10:0] exp11;
    frm_t        mfe;
    rd_t         mre;
    int          mnow;
    int          et;

    always @(negedge clk) begin
        if (mon_en) begin
            mnow = cyc + 1;
            if (SS_n === 1'b0) begin
                if (!in_frame) begin
                    in_frame = 1;
                    fstart   = mnow;
                    got      = '0;
                    nbits    = 0;
                    mosi_nz  = 0;
                end
                if (nbits < 11) got = {got[9:0], MOSI};
                else if (MOSI !== 1'b0) mosi_nz = 1;
                nbits++;
            end else if (in_frame) begin
                in_frame = 0;
                if (frm_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_frame: SS_n low %0d cycles from cycle %0d, required none",
                             nbits, fstart);
                end else begin
                    mfe   = frm_q.pop_front();
                    kbits = (nbits < 11) ? nbits : 11;
                    exp11 = {mfe.cmd[9], mfe.cmd};
                    check("frame_start", fstart, mfe.t + 1);
                    check("frame_len", nbits, mfe.len);
                    check("frame_bits", {21'd0, got}, {21'd0, exp11 >> (11 - kbits)});
                    check("mosi_quiet", {31'd0, mosi_nz}, 32'd0);
                    if (!mfe.aborted) check("ready_after_frame", {31'd0, cmd_ready}, 32'd1);
                end
            end
            if (rd_valid !== 1'b0) begin
                if (rd_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_rd_valid: rd_valid=%b rd_data=0x%0h, required no pulse",
                             rd_valid, rd_data);
                end else begin
                    mre = rd_q.pop_front();
                    check("rd_data", {24'd0, rd_data}, {24'd0, mre.b});
                    check("rd_valid_cycle", mnow, mre.t);
                    check("busy_at_rd_valid", {31'd0, busy}, 32'd0);
                end
            end
            if (seq_err !== 1'b0) begin
                if (err_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_seq_err: seq_err=%b, required 0", seq_err);
                end else begin
                    et = err_q.pop_front();
                    check("seq_err_cycle", mnow, et);
                end
            end
        end
    end

    initial begin
        int t1;
        int t2;
        int t3;
        int k;
        frm_t fe;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_data  = '0;
        MISO      = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ss_n", {31'd0, SS_n}, 32'd1);
        check("rst_mosi", {31'd0, MOSI}, 32'd0);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_rd_data", {24'd0, rd_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_seq_err", {31'd0, seq_err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", {31'd0, cmd_ready}, 32'd1);
        mon_en = 1;

        // rd-data straight after reset: rejected with the sequence check, framed otherwise
        send(10'h3AA, 8'hC3, 0, t1);
        repeat (2) @(negedge clk);
        send(10'h212, 8'h00, 0, t1);
        send(10'h3E1, 8'h96, 0, t1);

        // Write address 0x0AB
        send(10'h0AB, 8'h00, 0, t1);
        // Read sequence returning 0x5A
        send(10'h20F, 8'h00, 0, t1);
        send(10'h300, 8'h5A, 0, t1);

        // Back-to-back writes with cmd_valid held
        send(10'h155, 8'h00, 1, t1);
        send(10'h0F0, 8'h00, 1, t2);
        send(10'h13C, 8'h00, 0, t3);
        check("b2b_gap1", t2 - t1, 12);
        check("b2b_gap2", t3 - t2, 12);

        // Reset in cycle T+6 of a rd-data frame
        send(10'h2C4, 8'h00, 0, t1);
        send(10'h3C4, 8'hE7, 0, t1);
        repeat (5) @(negedge clk);
        fe = frm_q.pop_back();
        fe.len = 6;
        fe.aborted = 1;
        frm_q.push_back(fe);
        void'(rd_q.pop_back());
        void'(miso_q.pop_back());
        pending = 0;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ss_n", {31'd0, SS_n}, 32'd1);
        check("midrst_mosi", {31'd0, MOSI}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        send(10'h0A5, 8'h00, 0, t1);
        send(10'h281, 8'h00, 0, t1);
        send(10'h381, 8'h3C, 0, t1);

        // Randomised traffic
        for (int i = 0; i < 40; i++) begin
            send(10'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), t1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        cmd_valid = 1'b0;

        k = 0;
        while ((frm_q.size() != 0 || rd_q.size() != 0 || err_q.size() != 0 || busy) && k < 400)
        begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        check("drain_frames", frm_q.size(), 0);
        check("drain_reads", rd_q.size(), 0);
        check("drain_seq_errs", err_q.size(), 0);
        check("final_busy", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
